ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 Parameter DATA_W, 18, instruction/data word width.
REQ-002 Parameter ADDR_W, 14, memory address and PC width.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin execution from IDLE.
REQ-006 mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
REQ-007 mem_ack  in  1  memory handshake acknowledge.
REQ-008 neg  in  1  ALU sign flag of registered result.
REQ-009 lsb  in  1  ALU bit-0 flag of registered result.
REQ-010 mem_req  out  1  memory access request.
REQ-011 mem_we  out  1  write qualifier for mem_req.
REQ-012 mem_addr  out  ADDR_W  memory address.
REQ-013 alu_sel  out  4  ALU operation select.
REQ-014 imm  out  ADDR_W  IR[13:0] operand to datapath.
REQ-015 acc_we  out  1  accumulator write from ALU result.
REQ-016 acc_load  out  1  accumulator write from mem_rdata.
REQ-017 busy  out  1  high in every state except IDLE and HALT.
REQ-018 halted  out  1  high in HALT.

Function
REQ-019 Opcode = IR[17:14]: 0 NOP; 1-9 ALU ops (alu_sel = opcode); 10 JMP; 11 JN; 12 JODD; 13 LOAD; 14 STORE; 15 HALT.
REQ-020 States IDLE, FETCH, DECODE, EXEC, WB, MEM, HALT; IDLE->FETCH on start=1, else hold.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on edge with mem_ack=1, IR<=mem_rdata, pc<=pc+1 modulo 2^ADDR_W, ->DECODE.
REQ-022 DECODE (1 cycle): NOP->FETCH; ALU op->EXEC; JMP pc<=imm ->FETCH; JN pc<=imm if neg_f ->FETCH; JODD pc<=imm if lsb_f ->FETCH; LOAD/STORE->MEM; HALT->HALT.
REQ-023 EXEC (1 cycle): alu_sel=opcode, ->WB.
REQ-024 WB (1 cycle): alu_sel=opcode held, acc_we=1, neg_f<=neg, lsb_f<=lsb, ->FETCH.
REQ-025 MEM: mem_req=1, mem_addr=imm, mem_we=1 for STORE only; on mem_ack=1 ->FETCH; LOAD asserts acc_load=1 in that ack cycle only.
REQ-026 mem_req, mem_we, mem_addr held stable from assertion until the ack cycle; ack allowed in the first request cycle.
REQ-027 mem_ack while mem_req=0 is ignored.
REQ-028 alu_sel=0 outside EXEC/WB; acc_we, acc_load single-cycle pulses.
REQ-029 HALT is sticky until reset; start ignored; mem_req=0.
REQ-030 Untaken JN/JODD leave pc at fetched-address+1.
REQ-031 Flags neg_f/lsb_f change only in WB.

Reset
REQ-032 rst_n=0 immediately forces IDLE, pc=0, IR=0, neg_f=lsb_f=0 and all outputs 0, including mid-handshake.
REQ-033 After rst_n deasserts, no action until start=1.

Structure
REQ-034 Shared package proc_pkg holds DATA_W, ADDR_W, opcode constants, ALU select codes and state encoding.
REQ-035 Optional combinational sub-module ctrl_decode maps opcode to class (alu/jump/mem/halt/nop); FSM, PC, IR and flags stay in ctrl_unit.

Verification
REQ-036 Assert rst_n=0 during FETCH with mem_req=1 -> all outputs 0 same cycle, IDLE, pc=0.
REQ-037 mem[0]=18'h04004 (ADD, imm 4), ack 1 cycle after req -> alu_sel=1 for EXEC and WB, one acc_we pulse in WB, pc=1, imm=4.
REQ-038 SUB with neg=1 in WB, then JN imm 0x020 -> next fetch mem_addr=0x020; repeat with neg=0 -> mem_addr=pc+1.
REQ-039 LOAD imm 0x155, ack delayed 3 cycles -> mem_req high 4 cycles, mem_addr=0x155 stable, mem_we=0, single acc_load pulse; STORE -> mem_we=1.
REQ-040 Fetch at pc=0x3FFF -> pc=0x0000 after ack.
REQ-041 HALT opcode -> halted=1, busy=0, start pulses ignored, mem_req stays 0 until reset.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and types for the control unit: widths, opcodes, states, opcode classes.
package proc_pkg;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 14;
  localparam int OPC_W  = 4;

  // Opcode map (IR[17:14]); opcodes 1..9 are ALU operations.
  localparam logic [OPC_W-1:0] OP_NOP       = 4'd0;
  localparam logic [OPC_W-1:0] OP_ALU_FIRST = 4'd1;
  localparam logic [OPC_W-1:0] OP_ALU_LAST  = 4'd9;
  localparam logic [OPC_W-1:0] OP_JMP       = 4'd10;
  localparam logic [OPC_W-1:0] OP_JN        = 4'd11;
  localparam logic [OPC_W-1:0] OP_JODD      = 4'd12;
  localparam logic [OPC_W-1:0] OP_LOAD      = 4'd13;
  localparam logic [OPC_W-1:0] OP_STORE     = 4'd14;
  localparam logic [OPC_W-1:0] OP_HALT      = 4'd15;

  // ALU select codes: the select equals the ALU opcode; zero means no operation.
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_MEM    = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_JUMP = 3'd2,
    CLS_MEM  = 3'd3,
    CLS_HALT = 3'd4
  } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: groups the 16 opcodes into the classes the FSM branches on.
module ctrl_decode
  import proc_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class
);

  // Map opcode to class; NOP is the default so every code is covered.
  always_comb begin
    op_class = CLS_NOP;
    if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
      op_class = CLS_ALU;
    end else begin
      case (opcode)
        OP_JMP, OP_JN, OP_JODD: op_class = CLS_JUMP;
        OP_LOAD, OP_STORE:      op_class = CLS_MEM;
        OP_HALT:                op_class = CLS_HALT;
        default:                op_class = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle accumulator-machine controller: fetch/decode/execute FSM with PC, IR and ALU flags.
//
// Memory handshake: mem_req is the valid; mem_ack is the ready. Once mem_req rises, mem_req,
// mem_we and mem_addr stay constant until the cycle in which mem_ack=1 is seen; that cycle
// completes the transfer (ack may arrive in the first request cycle). mem_ack with mem_req=0
// has no effect.
module ctrl_unit #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              neg,
  input  logic              lsb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        alu_sel,
  output logic [ADDR_W-1:0] imm,
  output logic              acc_we,
  output logic              acc_load,
  output logic              busy,
  output logic              halted
);

  import proc_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] ir, ir_nxt;
  logic              neg_f, neg_nxt;
  logic              lsb_f, lsb_nxt;
  logic [3:0]        opcode;
  op_class_t         op_class;
  logic              jump_taken;

  assign opcode = ir[DATA_W-1 -: 4];
  assign imm    = ir[ADDR_W-1:0];

  ctrl_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // Unconditional JMP, or a conditional jump whose latched flag is set.
  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JN)   && neg_f) ||
                      ((opcode == OP_JODD) && lsb_f);

  // State, PC, IR and flag registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      neg_f <= 1'b0;
      lsb_f <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      neg_f <= neg_nxt;
      lsb_f <= lsb_nxt;
    end
  end

  // Next-state logic and Moore/Mealy outputs; all outputs default to 0.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    neg_nxt   = neg_f;
    lsb_nxt   = lsb_f;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    alu_sel   = ALU_NONE;
    acc_we    = 1'b0;
    acc_load  = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_HALT);
    halted    = (state == ST_HALT);
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op_class)
          CLS_ALU:  state_nxt = ST_EXEC;
          CLS_MEM:  state_nxt = ST_MEM;
          CLS_HALT: state_nxt = ST_HALT;
          CLS_JUMP: begin
            if (jump_taken) pc_nxt = imm;
            state_nxt = ST_FETCH;
          end
          default:  state_nxt = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        alu_sel   = opcode;
        state_nxt = ST_WB;
      end
      ST_WB: begin
        alu_sel   = opcode;
        acc_we    = 1'b1;
        neg_nxt   = neg;
        lsb_nxt   = lsb;
        state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = imm;
        mem_we   = (opcode == OP_STORE);
        if (mem_ack) begin
          acc_load  = (opcode == OP_LOAD);
          state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: single-instruction vector table plus multi-cycle sequences.
module tb_ctrl_unit;

  localparam int DW = 18;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          neg, lsb;
  logic          mem_req, mem_we, acc_we, acc_load, busy, halted;
  logic [AW-1:0] mem_addr, imm;
  logic [3:0]    alu_sel;
  logic [37:0]   outvec;

  int neg_mode = 0;  // 0: low, 1: high, 2: high except during WB (acc_we)
  int lsb_mode = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    int            len;
  } req_t;
  req_t log_q[$];
  logic [AW:0] exp_q[$];

  logic          in_req;
  logic [AW-1:0] cur_addr;
  logic          cur_we;
  int            cur_len;
  int            acc_we_cnt, acc_load_cnt, alu_cycles, mem_we_cycles, stable_err;
  logic [3:0]    alu_last;
  logic [AW-1:0] imm_at_we;

  assign neg = (neg_mode == 2) ? !acc_we : (neg_mode == 1);
  assign lsb = (lsb_mode == 2) ? !acc_we : (lsb_mode == 1);
  assign outvec = {mem_req, mem_we, mem_addr, alu_sel, imm, acc_we, acc_load, busy, halted};

  ctrl_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .neg       (neg),
    .lsb       (lsb),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .alu_sel   (alu_sel),
    .imm       (imm),
    .acc_we    (acc_we),
    .acc_load  (acc_load),
    .busy      (busy),
    .halted    (halted)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: acks after ack_delay wait cycles of an active request
  always @(negedge clk) begin
    if (!rst_n || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_we ? '0 : mem[mem_addr];
      wait_cnt  = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = wait_cnt + 1;
    end
  end

  // Monitor: logs completed requests, counts pulses, flags unstable requests
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (mem_req) begin
        if (!in_req) begin
          in_req   = 1'b1;
          cur_addr = mem_addr;
          cur_we   = mem_we;
          cur_len  = 0;
        end else if (mem_addr !== cur_addr || mem_we !== cur_we) begin
          stable_err++;
        end
        cur_len++;
        if (mem_we) mem_we_cycles++;
        if (mem_ack) begin
          req_t r;
          r.addr = cur_addr;
          r.we   = cur_we;
          r.len  = cur_len;
          log_q.push_back(r);
          in_req = 1'b0;
        end
      end else begin
        if (in_req) stable_err++;
        in_req = 1'b0;
        if (mem_we) stable_err++;
      end
      if (acc_we) begin
        acc_we_cnt++;
        imm_at_we = imm;
      end
      if (acc_load) acc_load_cnt++;
      if (alu_sel != 4'd0) begin
        alu_cycles++;
        alu_last = alu_sel;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reqs(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size())
        chk($sformatf("%s[%0d]", name, i), {log_q[i].we, log_q[i].addr}, exp_q[i]);
      else
        chk($sformatf("%s_count", name), log_q.size(), i + 1);
    end
  endtask

  task automatic clear_mon();
    log_q.delete();
    in_req = 1'b0;
    acc_we_cnt = 0;
    acc_load_cnt = 0;
    alu_cycles = 0;
    mem_we_cycles = 0;
    stable_err = 0;
    alu_last = '0;
    imm_at_we = '0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    neg_mode = 0;
    lsb_mode = 0;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    clear_mon();
    clear_mem();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  typedef struct {
    string         name;
    logic [DW-1:0] instr;
    int            exp_we;
    int            exp_load;
    int            exp_alu_cyc;
    logic [3:0]    exp_alu;
    logic          exp_halt;
    logic [AW:0]   exp_next;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [DW-1:0] ins, input int we,
                              input int ld, input int ac, input logic [3:0] al,
                              input logic h, input logic [AW:0] nx);
    vec_t v;
    v.name = n; v.instr = ins; v.exp_we = we; v.exp_load = ld;
    v.exp_alu_cyc = ac; v.exp_alu = al; v.exp_halt = h; v.exp_next = nx;
    return v;
  endfunction

  typedef struct {
    string         name;
    logic [DW-1:0] jinstr;
    int            nm;
    int            lm;
    logic [AW:0]   exp_tgt;
  } jvec_t;

  vec_t  vecs[9];
  jvec_t jvecs[5];

  initial begin
    vecs[0] = mk("nop",   18'h00000, 0, 0, 0, 4'd0, 1'b0, 15'h0001);
    vecs[1] = mk("add",   18'h04004, 1, 0, 2, 4'd1, 1'b0, 15'h0001);
    vecs[2] = mk("alu9",  18'h24003, 1, 0, 2, 4'd9, 1'b0, 15'h0001);
    vecs[3] = mk("jmp",   18'h28123, 0, 0, 0, 4'd0, 1'b0, 15'h0123);
    vecs[4] = mk("jn_nf", 18'h2C020, 0, 0, 0, 4'd0, 1'b0, 15'h0001);
    vecs[5] = mk("jodd",  18'h30020, 0, 0, 0, 4'd0, 1'b0, 15'h0001);
    vecs[6] = mk("load",  18'h34155, 0, 1, 0, 4'd0, 1'b0, 15'h0155);
    vecs[7] = mk("store", 18'h38155, 0, 0, 0, 4'd0, 1'b0, 15'h4155);
    vecs[8] = mk("halt",  18'h3C000, 0, 0, 0, 4'd0, 1'b1, 15'h0000);

    jvecs[0] = '{"jn_neg1",    18'h2C020, 1, 0, 15'h0020};
    jvecs[1] = '{"jn_neg0",    18'h2C020, 0, 0, 15'h0002};
    jvecs[2] = '{"jn_neg_nowb", 18'h2C020, 2, 0, 15'h0002};
    jvecs[3] = '{"jodd_lsb1",  18'h30020, 0, 1, 15'h0020};
    jvecs[4] = '{"jodd_lsb0",  18'h30020, 0, 0, 15'h0002};

    clear_mon();
    clear_mem();

    // Reset state
    #12;
    chk("reset_outputs", outvec, '0);
    rst_n = 1'b1;
    run(3);
    chk("idle_without_start", {busy, mem_req}, 2'b00);

    // Single-instruction table, each from reset with immediate ack
    for (int i = 0; i < 9; i++) begin
      do_reset();
      mem[0] = vecs[i].instr;
      pulse_start();
      run(12);
      chk({vecs[i].name, "_halted"}, halted, vecs[i].exp_halt);
      chk({vecs[i].name, "_acc_we"}, acc_we_cnt, vecs[i].exp_we);
      chk({vecs[i].name, "_acc_load"}, acc_load_cnt, vecs[i].exp_load);
      chk({vecs[i].name, "_alu_cycles"}, alu_cycles, vecs[i].exp_alu_cyc);
      chk({vecs[i].name, "_alu_sel"}, alu_last, vecs[i].exp_alu);
      chk({vecs[i].name, "_stable"}, stable_err, 0);
      if (vecs[i].exp_halt) begin
        chk({vecs[i].name, "_nreq"}, log_q.size(), 1);
      end else begin
        exp_q = '{15'h0000, vecs[i].exp_next};
        chk_reqs({vecs[i].name, "_req"});
      end
    end

    // Reset in the middle of a stalled fetch
    do_reset();
    pulse_start();
    run(6);
    ack_delay = 10;
    run(3);
    chk("stall_in_fetch", mem_req, 1'b1);
    chk("pc_advanced", (mem_addr != '0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("outputs_zero_in_reset", outvec, '0);
    repeat (2) @(negedge clk);
    clear_mon();
    ack_delay = 0;
    rst_n = 1'b1;
    run(4);
    chk("idle_after_reset_busy", busy, 1'b0);
    chk("idle_after_reset_reqs", log_q.size(), 0);
    pulse_start();
    run(4);
    exp_q = '{15'h0000};
    chk_reqs("restart_pc0");

    // ADD with one-cycle ack latency
    do_reset();
    mem[0] = 18'h04004;
    ack_delay = 1;
    pulse_start();
    run(14);
    exp_q = '{15'h0000, 15'h0001};
    chk_reqs("add_lat1");
    chk("add_lat1_fetch_len", log_q.size() > 0 ? log_q[0].len : 0, 2);
    chk("add_lat1_alu_cycles", alu_cycles, 2);
    chk("add_lat1_alu_sel", alu_last, 4'd1);
    chk("add_lat1_acc_we", acc_we_cnt, 1);
    chk("add_lat1_imm", imm_at_we, 14'd4);

    // Conditional jumps after an ALU op that sets the flags
    for (int i = 0; i < 5; i++) begin
      do_reset();
      mem[0] = 18'h08000;
      mem[1] = jvecs[i].jinstr;
      neg_mode = jvecs[i].nm;
      lsb_mode = jvecs[i].lm;
      pulse_start();
      run(12);
      exp_q = '{15'h0000, 15'h0001, jvecs[i].exp_tgt};
      chk_reqs(jvecs[i].name);
    end

    // LOAD and STORE with three wait cycles
    for (int i = 0; i < 2; i++) begin
      do_reset();
      mem[0] = (i == 0) ? 18'h34155 : 18'h38155;
      ack_delay = 3;
      pulse_start();
      run(20);
      exp_q = '{15'h0000, (i == 0) ? 15'h0155 : 15'h4155, 15'h0001};
      chk_reqs(i == 0 ? "load_wait" : "store_wait");
      chk(i == 0 ? "load_len" : "store_len", log_q.size() > 1 ? log_q[1].len : 0, 4);
      chk(i == 0 ? "load_pulses" : "store_pulses", acc_load_cnt, (i == 0) ? 1 : 0);
      chk(i == 0 ? "load_we_cycles" : "store_we_cycles", mem_we_cycles, (i == 0) ? 0 : 4);
      chk(i == 0 ? "load_stable" : "store_stable", stable_err, 0);
    end

    // PC wrap at the top of the address space
    do_reset();
    mem[0] = 18'h2BFFF;
    pulse_start();
    run(10);
    exp_q = '{15'h0000, 15'h3FFF, 15'h0000};
    chk_reqs("pc_wrap");

    // HALT is sticky and ignores start
    do_reset();
    mem[0] = 18'h3C000;
    pulse_start();
    run(6);
    chk("halt_state", {halted, busy}, 2'b10);
    repeat (3) begin
      pulse_start();
      run(2);
    end
    chk("halt_sticky", {halted, busy, mem_req}, 3'b100);
    chk("halt_no_requests", log_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
